// File: rtl/data_ram_pkg.sv
// Shared types and helpers for data_ram: FSM state encoding, geometry helpers
// and the byte-lane merge used by the write path and the optional bypass.
package data_ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

  // Number of byte-offset address bits for a word of data_w bits.
  function automatic int unsigned calc_off_w(input int unsigned data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

  // Number of word-index address bits for depth words.
  function automatic int unsigned calc_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One byte lane of a strobed write: new byte when strobed, old byte otherwise.
  function automatic logic [BYTE_W-1:0] lane_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              strb
  );
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/data_ram_init_ctrl.sv
// Clear-on-reset sequencer for data_ram: walks every word once after reset,
// asking the top to write zero, then parks in READY.
module data_ram_init_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = calc_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [IDX_W-1:0] clr_idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  ram_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one word cleared per INIT cycle, leave after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Outputs decode directly from the state and counter flops.
  always_comb begin
    busy_o    = 1'b0;
    clr_we_o  = 1'b0;
    clr_idx_o = cnt_q;
    if (state_q == INIT) begin
      busy_o   = 1'b1;
      clr_we_o = 1'b1;
    end
  end

endmodule

// File: rtl/data_ram.sv
// Parametrised single-clock data memory with byte strobes, registered read,
// out-of-range error pulse and a clear sweep after reset (busy_o).
// Optional macro DATA_RAM_BYPASS_EN: same-word read/write returns write-first data.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned STRB_W  = DATA_W / BYTE_W;
  localparam int unsigned OFF_W   = calc_off_w(DATA_W);
  localparam int unsigned IDX_W   = calc_idx_w(DEPTH);
  localparam int unsigned TOP_LSB = OFF_W + IDX_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wr_oor, rd_oor;
  logic             wr_acc, rd_acc;
  logic [DATA_W-1:0] wr_old, wr_merged, rd_word;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  data_ram_init_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_idx_o (clr_idx)
  );

  // Address decode: byte offset dropped, any bit above the index is out of range.
  assign wr_idx = wr_addr_i[TOP_LSB-1:OFF_W];
  assign rd_idx = rd_addr_i[TOP_LSB-1:OFF_W];
  assign wr_oor = |(wr_addr_i >> TOP_LSB);
  assign rd_oor = |(rd_addr_i >> TOP_LSB);
  assign wr_acc = wr_en_i && !busy;
  assign rd_acc = rd_en_i && !busy;

  // Strobed write word built from the current contents.
  always_comb begin
    wr_old    = mem_q[wr_idx];
    wr_merged = wr_old;
    for (int k = 0; k < STRB_W; k++) begin
      wr_merged[k*BYTE_W +: BYTE_W] = lane_merge(wr_old[k*BYTE_W +: BYTE_W],
                                                 wr_data_i[k*BYTE_W +: BYTE_W],
                                                 wr_strb_i[k]);
    end
  end

  // Storage: the clear sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_acc && !wr_oor) begin
      mem_q[wr_idx] <= wr_merged;
    end
  end

`ifdef DATA_RAM_BYPASS_EN
  assign rd_word = (wr_acc && !wr_oor && (wr_idx == rd_idx)) ? wr_merged : mem_q[rd_idx];
`else
  assign rd_word = mem_q[rd_idx];
`endif

  // Read register, valid and error pulses.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = (rd_acc && rd_oor) || (wr_acc && wr_oor);
    if (rd_acc) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_oor ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;
  assign busy_o     = busy;

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram at DEPTH=16, DATA_W=32.
module tb_data_ram;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 16;
  localparam int unsigned AW  = 32;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic          busy_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  data_ram #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_strb = 4'h0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    step();
    step();
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL reset_busy got=%0b want=1", busy_o);
    end
    total++;
    if ({rd_valid_o, err_o, rd_data_o} !== {1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL reset_outputs got valid=%0b err=%0b data=%h want 0/0/0",
                      rd_valid_o, err_o, rd_data_o);
    end
    rst = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      step();
    end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL busy_cycles got=%0d want=16", n);
    end
  endtask

  task automatic test_sweep_zero();
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = 32'(i * 4);
      step();
      total++;
      if ({rd_valid_o, err_o, rd_data_o} !== {1'b1, 1'b0, 32'h0}) begin
        bad++; $display("FAIL sweep_read[%0d] got valid=%0b err=%0b data=%h want 1/0/00000000",
                        i, rd_valid_o, err_o, rd_data_o);
      end
    end
    idle();
    step();
    total++;
    if (rd_valid_o !== 1'b0) begin
      bad++; $display("FAIL valid_drop got=%0b want=0", rd_valid_o);
    end
  endtask

  task automatic test_strobe();
    wr_en = 1'b1; wr_addr = 32'h08; wr_data = 32'hAABBCCDD; wr_strb = 4'b1111;
    step();
    wr_data = 32'h11223344; wr_strb = 4'b0101;
    step();
    wr_data = 32'hFFFFFFFF; wr_strb = 4'b0000;
    step();
    idle();
    rd_en = 1'b1; rd_addr = 32'h08;
    step();
    total++;
    if ({rd_valid_o, rd_data_o} !== {1'b1, 32'hAA22CC44}) begin
      bad++; $display("FAIL strobe_merge got valid=%0b data=%h want 1/aa22cc44",
                      rd_valid_o, rd_data_o);
    end
    idle();
    step();
    total++;
    if ({rd_valid_o, rd_data_o} !== {1'b0, 32'hAA22CC44}) begin
      bad++; $display("FAIL data_hold got valid=%0b data=%h want 0/aa22cc44",
                      rd_valid_o, rd_data_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] exp_rd;
`ifdef DATA_RAM_BYPASS_EN
    exp_rd = 32'hDEADBEEF;
`else
    exp_rd = 32'h00000000;
`endif
    wr_en = 1'b1; wr_addr = 32'h0C; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    rd_en = 1'b1; rd_addr = 32'h0C;
    step();
    total++;
    if ({rd_valid_o, rd_data_o} !== {1'b1, exp_rd}) begin
      bad++; $display("FAIL same_word_rw got valid=%0b data=%h want 1/%h",
                      rd_valid_o, rd_data_o, exp_rd);
    end
    wr_en = 1'b0;
    step();
    total++;
    if (rd_data_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL same_word_after got=%h want=deadbeef", rd_data_o);
    end
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h00000055; wr_strb = 4'hF;
    rd_addr = 32'h08;
    step();
    total++;
    if (rd_data_o !== 32'hAA22CC44) begin
      bad++; $display("FAIL diff_word_rw got=%h want=aa22cc44", rd_data_o);
    end
    wr_en = 1'b0; rd_addr = 32'h10;
    step();
    total++;
    if (rd_data_o !== 32'h00000055) begin
      bad++; $display("FAIL diff_word_wr got=%h want=00000055", rd_data_o);
    end
    idle();
    step();
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_addr = 32'h04; wr_data = 32'h0000CAFE; wr_strb = 4'hF;
    step();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL inrange_wr_err got=%0b want=0", err_o);
    end
    wr_addr = 32'h44; wr_data = 32'h00000005;
    step();
    total++;
    if ({err_o, rd_valid_o} !== 2'b10) begin
      bad++; $display("FAIL oor_wr_err got err=%0b valid=%0b want 1/0", err_o, rd_valid_o);
    end
    idle();
    rd_en = 1'b1; rd_addr = 32'h04;
    step();
    total++;
    if ({rd_valid_o, err_o, rd_data_o} !== {1'b1, 1'b0, 32'h0000CAFE}) begin
      bad++; $display("FAIL oor_wr_nomod got valid=%0b err=%0b data=%h want 1/0/0000cafe",
                      rd_valid_o, err_o, rd_data_o);
    end
    rd_addr = 32'h40;
    step();
    total++;
    if ({rd_valid_o, err_o, rd_data_o} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL oor_rd got valid=%0b err=%0b data=%h want 1/1/00000000",
                      rd_valid_o, err_o, rd_data_o);
    end
    idle();
    step();
    total++;
    if ({rd_valid_o, err_o} !== 2'b00) begin
      bad++; $display("FAIL oor_pulse_end got valid=%0b err=%0b want 0/0", rd_valid_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; rd_addr = 32'h40;
    wr_en = 1'b1; wr_addr = 32'h100; wr_data = 32'h1; wr_strb = 4'hF;
    step();
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL b2b_err0 got=%0b want=1", err_o);
    end
    wr_en = 1'b0; rd_addr = 32'h80;
    step();
    total++;
    if (err_o !== 1'b1) begin
      bad++; $display("FAIL b2b_err1 got=%0b want=1", err_o);
    end
    rd_addr = 32'h3C;
    step();
    total++;
    if ({err_o, rd_valid_o} !== 2'b01) begin
      bad++; $display("FAIL b2b_err_end got err=%0b valid=%0b want 0/1", err_o, rd_valid_o);
    end
    idle();
    step();
  endtask

  task automatic test_busy_ignore();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      wr_en   = 1'b1;
      wr_addr = (n % 2 == 1) ? 32'h00 : 32'h3C;
      wr_data = 32'hFFFFFFFF;
      wr_strb = 4'hF;
      rd_en   = 1'b1;
      rd_addr = (n % 2 == 1) ? 32'h40 : 32'h00;
      step();
      n++;
      total++;
      if ({rd_valid_o, err_o, rd_data_o} !== {1'b0, 1'b0, 32'h0}) begin
        bad++; $display("FAIL busy_ignore[%0d] got valid=%0b err=%0b data=%h want 0/0/00000000",
                        n, rd_valid_o, err_o, rd_data_o);
      end
    end
    idle();
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL busy_ignore_cycles got=%0d want=16", n);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 32'(i * 4);
      step();
      total++;
      if ({rd_valid_o, rd_data_o} !== {1'b1, 32'h0}) begin
        bad++; $display("FAIL busy_mem[%0d] got valid=%0b data=%h want 1/00000000",
                        i, rd_valid_o, rd_data_o);
      end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'h00001234; wr_strb = 4'hF;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 32'h14;
    step();
    total++;
    if (rd_data_o !== 32'h00001234) begin
      bad++; $display("FAIL pre_sweep_wr got=%h want=00001234", rd_data_o);
    end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
    end
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL mid_sweep_busy got=%0b want=1", busy_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      step();
    end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL restart_busy_cycles got=%0d want=16", n);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; rd_addr = 32'(i * 4);
      step();
      total++;
      if ({rd_valid_o, rd_data_o} !== {1'b1, 32'h0}) begin
        bad++; $display("FAIL restart_mem[%0d] got valid=%0b data=%h want 1/00000000",
                        i, rd_valid_o, rd_data_o);
      end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_sweep_zero();
    test_strobe();
    test_same_cycle();
    test_out_of_range();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Parametrised single-clock data memory for the core's load/store path; the successor of the fixed 32-word RAM.
- Configurable depth and width, per-byte write strobes, read-enable with a registered valid, and an out-of-range error flag.
- Hardware clear-on-reset sweep, signalled by busy_o.
- Sits behind the MEM stage; write port and read port are independent and usable in the same cycle.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8, at least 8.
- DEPTH, 32, number of words; must be a power of two, at least 2.
- ADDR_W, 32, width of the byte address inputs.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- wr_en_i  in  1  write request.
- wr_addr_i  in  ADDR_W  write byte address.
- wr_data_i  in  DATA_W  write data.
- wr_strb_i  in  DATA_W/8  byte-lane write enables; bit k covers wr_data_i[8k+7:8k].
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_W  read byte address.
- rd_data_o  out  DATA_W  read data, registered.
- rd_valid_o  out  1  one-cycle pulse: rd_data_o is updated this cycle.
- busy_o  out  1  clear sweep in progress; all requests are ignored.
- err_o  out  1  one-cycle pulse: an accepted access was out of range.

Behaviour:
- Definitions:
  - OFF = log2(DATA_W/8); IDX = log2(DEPTH).
  - Word index = addr[OFF+IDX-1:OFF]. Address bits below OFF are ignored; no misalignment trap.
  - An address is out of range when any of addr[ADDR_W-1:OFF+IDX] is nonzero.
- Reset values while rst=1: rd_data_o=0, rd_valid_o=0, err_o=0, busy_o=1; the sweep counter is held at 0.
- FSM states are INIT and READY.
  - rst forces INIT with counter=0.
  - In INIT, each cycle writes 0 to word[counter] and increments counter.
  - When counter=DEPTH-1 is written, the next state is READY.
  - busy_o=1 exactly in INIT, so it is high for DEPTH cycles after rst falls.
  - rst asserted mid-sweep restarts the sweep at word 0.
- In INIT, wr_en_i and rd_en_i are dropped: no memory change, no rd_valid_o, no err_o, and rd_data_o holds its value.
- Writes (READY only):
  - Accepted when wr_en_i=1.
  - Each lane with strobe=1 is written at the clock edge; lanes with strobe=0 keep their old value.
  - wr_strb_i=0 is a legal no-op.
  - An out-of-range write does not modify memory and raises err_o the next cycle.
- Reads (READY only):
  - Accepted when rd_en_i=1.
  - Latency 1: rd_data_o and rd_valid_o=1 appear on the cycle after acceptance.
  - rd_valid_o=0 on cycles without an accepted read, and rd_data_o holds its last value.
  - An out-of-range read returns rd_data_o=0 with rd_valid_o=1 and err_o=1.
- err_o:
  - Also pulses once if a read and a write in the same cycle are both out of range.
  - Back-to-back accepted accesses give back-to-back pulses.
- Read and write to the same word in the same cycle:
  - By default the read returns the pre-write contents (read-first); see the optional feature.
- Read and write to different words in the same cycle are fully independent.

Optional Feature:
- Macro: DATA_RAM_BYPASS_EN.
- Defined: a same-cycle read and write to the same in-range word return the write-first result. For each lane, the byte comes from wr_data_i if its strobe is 1, otherwise from the old contents.
- Undefined: read-first (old contents). There is no extra bypass logic and timing is identical.

Decomposition:
- Shared package data_ram_pkg holds:
  - the state enum (INIT, READY);
  - helper functions for OFF/IDX computation (clog2-based);
  - the lane-merge function (old word, new word, strobe) used by both the write path and the bypass.
- Sub-module data_ram_init_ctrl holds the INIT/READY FSM and the sweep counter. It outputs busy, clr_we and clr_idx, which the top muxes into the write port.
- The storage array, read register and error logic stay in data_ram.

Test Plan:
- DEPTH=16, DATA_W=32: release rst -> busy_o=1 for exactly 16 cycles; then a read of every word returns 0x00000000 with rd_valid_o one cycle after rd_en_i.
- Write 0xAABBCCDD at 0x08, strb=4'b1111, then write 0x11223344 at 0x08, strb=4'b0101, then read 0x08 -> 0xAA22CC44.
- Write and read 0x0C in the same cycle, old value 0x0, data 0xDEADBEEF, strb=4'hF:
  - without the macro -> 0x00000000, then the next read gives 0xDEADBEEF;
  - with DATA_RAM_BYPASS_EN -> 0xDEADBEEF.
- Read 0x40 (out of range for 16 words) -> rd_data_o=0, rd_valid_o=1, err_o=1. Write 0x44 with data 0x5, then read 0x04 -> previous value unchanged and err_o pulsed for the write.
- Assert rst for 1 cycle at sweep count 7 after writing 0x1234 earlier -> sweep restarts, busy_o high 16 more cycles, all words read 0.
- During busy_o, issue rd_en_i and wr_en_i -> rd_valid_o stays 0, err_o stays 0, rd_data_o unchanged, and memory is 0 afterwards.
